// File: rtl/lwdo_pkg.sv
// Shared constants for the lwdo register block and its ADC stream feeders.
package lwdo_pkg;

  localparam int LWDO_WORD_W = 32;
  localparam int LWDO_SMP_W  = 16;

  localparam logic [LWDO_WORD_W-1:0] LWDO_EMPTY_WORD = 32'h0000_0000;

  typedef enum logic {
    HALF0,
    HALF1
  } pack_state_e;

endpackage

// File: rtl/lwdo_adcstr_fifo_if.sv
// Sample-in / word-out signal bundle of one ADC stream feeder.
interface lwdo_adcstr_fifo_if;
  import lwdo_pkg::*;

  logic                   smp_valid;
  logic [LWDO_SMP_W-1:0]  smp_data;
  logic [LWDO_WORD_W-1:0] rx_data;
  logic                   rx_data_read_trigger;

  modport master (
    output smp_valid, smp_data, rx_data_read_trigger,
    input  rx_data
  );

  modport slave (
    input  smp_valid, smp_data, rx_data_read_trigger,
    output rx_data
  );

endinterface

// File: rtl/lwdo_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with flush, level and
// drop/underflow pulses; head is combinational from the registered read pointer.
module lwdo_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  drop,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full, pop_ok, push_ok;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LVL_FULL);
    pop_ok    = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push_ok   = push & ~flush & (~full | pop_ok);
    drop      = push & ~flush & ~push_ok;
    underflow = pop & ~flush & empty;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
      else if (pop_ok && !push_ok) level_d = level_q - LVL_ONE;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level gates every read, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/lwdo_adcstr_fifo.sv
// ADC stream feeder: packs sample pairs into 32-bit words (first sample low),
// buffers them in a FWFT FIFO and keeps sticky overflow/underflow flags.
module lwdo_adcstr_fifo
  import lwdo_pkg::*;
#(
  parameter int                     DEPTH_LOG2 = 5,
  parameter logic [LWDO_WORD_W-1:0] EMPTY_WORD = LWDO_EMPTY_WORD
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_clear,
  lwdo_adcstr_fifo_if.slave       bus,
  output logic [DEPTH_LOG2:0]     o_level,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  pack_state_e            state_q, state_d;
  logic [LWDO_SMP_W-1:0]  lo_q, lo_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   push;
  logic [LWDO_WORD_W-1:0] push_word;
  logic [LWDO_WORD_W-1:0] fifo_head;
  logic [DEPTH_LOG2:0]    fifo_level;
  logic                   fifo_empty, fifo_drop, fifo_underflow;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push      = 1'b0;
    push_word = {bus.smp_data, lo_q};
    // Disable or clear drops any held low half; a partial word never reaches the FIFO.
    if (i_clear || !i_enable) begin
      state_d = HALF0;
    end else if (bus.smp_valid) begin
      case (state_q)
        HALF0: begin
          lo_d    = bus.smp_data;
          state_d = HALF1;
        end
        HALF1: begin
          push    = 1'b1;
          state_d = HALF0;
        end
      endcase
    end

    overflow_d  = i_clear ? 1'b0 : (overflow_q  | fifo_drop);
    underflow_d = i_clear ? 1'b0 : (underflow_q | fifo_underflow);
  end

  // NOTE: reset is synchronous; i_rst_n is only looked at on the clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= HALF0;
      lo_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  lwdo_sync_fifo #(
    .WIDTH      (LWDO_WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_clear),
    .push       (push),
    .push_data  (push_word),
    .pop        (bus.rx_data_read_trigger),
    .head       (fifo_head),
    .level      (fifo_level),
    .empty      (fifo_empty),
    .drop       (fifo_drop),
    .underflow  (fifo_underflow)
  );

  assign bus.rx_data = fifo_empty ? EMPTY_WORD : fifo_head;
  assign o_level     = fifo_level;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule
